// File: rtl/clkdiv_seq_pkg.sv
// Package shared by the CLKDIV phase sequencer and its timer.
// Contents:
//   seq_state_e        sequencer states HOLD..RUN
//   div_mode_is_legal  divide ratios the controlled CLKDIV supports
//   phase_width        width of the phase/delta fields for a divide ratio
//   count_width        width of the shared down-counter for the given delays
package clkdiv_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_RUN    = 3'd4
    } seq_state_e;

    function automatic bit div_mode_is_legal(input int div_mode);
        bit legal_s;
        case (div_mode)
            32'sd2, 32'sd4, 32'sd5, 32'sd8: legal_s = 1'b1;
            default:                        legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

    // At least one bit even for a divide-by-2 phase.
    function automatic int phase_width(input int div_mode);
        return (div_mode > 32'sd2) ? $clog2(div_mode) : 32'sd1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int count_width(input int reset_cycles, input int settle_cycles,
                                       input int calib_width, input int calib_gap);
        return $clog2(max2(max2(reset_cycles, settle_cycles),
                           max2(calib_width, calib_gap)) + 32'sd1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by every timed state of the sequencer.
// Ports:
//   clk         clock
//   reset       synchronous active-high; loads RESET_VALUE
//   load        load strobe; takes priority over counting
//   load_value  value loaded on the strobe (terminal count - 1)
//   done        registered flag, high while the count sits at zero
module seq_timer #(
    parameter int CW          = 5,
    parameter int RESET_VALUE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          done
);

    logic [CW-1:0] count_r;

    // Reload on strobe, otherwise count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CW'(RESET_VALUE);
            done    <= (RESET_VALUE == 32'sd0);
        end else if (load) begin
            count_r <= load_value;
            done    <= (load_value == '0);
        end else if (count_r != '0) begin
            count_r <= count_r - CW'(1);
            done    <= (count_r == CW'(1));
        end else begin
            count_r <= count_r;
            done    <= 1'b1;
        end
    end

endmodule

// File: rtl/clkdiv_phase_sequencer.sv
// Sequencer for a CLKDIV instance in the coil drive clock tree. Holds the
// divider in reset, lets it settle, then issues CALIB pulses to rotate the
// divided clock phase; afterwards accepts phase-step requests.
// Ports:
//   clk          divider source clock (HCLKIN net)
//   reset        synchronous active-high
//   start        1-cycle pulse: full resync
//   phase_valid  phase-step request valid
//   phase_delta  steps to advance, taken modulo DIV_MODE
//   phase_ready  request accepted when phase_valid && phase_ready
//   div_resetn   to CLKDIV RESETN
//   div_calib    to CLKDIV CALIB
//   ready        divider running, phase stable
//   busy         inverse of ready
//   phase        accumulated steps since last (re)start, modulo DIV_MODE
module clkdiv_phase_sequencer
    import clkdiv_seq_pkg::*;
#(
    parameter int  DIV_MODE      = 4,
    parameter int  RESET_CYCLES  = 16,
    parameter int  SETTLE_CYCLES = 32,
    parameter int  CALIB_WIDTH   = 2,
    parameter int  CALIB_GAP     = 8,
    parameter int  INIT_PHASE    = 0,
    localparam int PHW           = phase_width(DIV_MODE)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           phase_valid,
    input  logic [PHW-1:0] phase_delta,
    output logic           phase_ready,
    output logic           div_resetn,
    output logic           div_calib,
    output logic           ready,
    output logic           busy,
    output logic [PHW-1:0] phase
);

    localparam int CW = count_width(RESET_CYCLES, SETTLE_CYCLES, CALIB_WIDTH, CALIB_GAP);

    localparam logic [CW-1:0]  LOAD_HOLD    = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]  LOAD_SETTLE  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  LOAD_PULSE   = CW'(CALIB_WIDTH - 1);
    localparam logic [CW-1:0]  LOAD_GAP     = CW'(CALIB_GAP - 1);
    localparam logic [PHW-1:0] INIT_PENDING = PHW'(INIT_PHASE);
    localparam logic [PHW-1:0] PHASE_MAX    = PHW'(DIV_MODE - 1);

    if (!div_mode_is_legal(DIV_MODE)) begin : g_bad_div_mode
        $error("clkdiv_phase_sequencer: unsupported DIV_MODE %0d", DIV_MODE);
    end

    seq_state_e     state_r;
    seq_state_e     next_state_s;
    logic [PHW-1:0] pending_r;
    logic [PHW-1:0] delta_mod_s;
    logic [PHW-1:0] phase_inc_s;
    logic           accept_s;
    logic           timer_load_s;
    logic [CW-1:0]  timer_value_s;
    logic           timer_done_s;

    seq_timer #(
        .CW          (CW),
        .RESET_VALUE (RESET_CYCLES - 1)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load_s),
        .load_value (timer_value_s),
        .done       (timer_done_s)
    );

    // Next state, handshake and timer reload for the state being entered.
    always_comb begin
        next_state_s  = state_r;
        timer_load_s  = 1'b0;
        timer_value_s = LOAD_HOLD;
        delta_mod_s   = PHW'(32'(phase_delta) % 32'(DIV_MODE));
        phase_inc_s   = (phase == PHASE_MAX) ? '0 : phase + PHW'(1);
        // start has priority, so a request coinciding with it is not consumed
        accept_s      = (state_r == ST_RUN) && phase_valid && phase_ready && !start;
        if (start) begin
            next_state_s  = ST_HOLD;
            timer_load_s  = 1'b1;
            timer_value_s = LOAD_HOLD;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (timer_done_s) begin
                        next_state_s  = ST_SETTLE;
                        timer_load_s  = 1'b1;
                        timer_value_s = LOAD_SETTLE;
                    end else begin
                        next_state_s  = ST_HOLD;
                    end
                end
                ST_SETTLE, ST_GAP: begin
                    if (timer_done_s && (pending_r != '0)) begin
                        next_state_s  = ST_PULSE;
                        timer_load_s  = 1'b1;
                        timer_value_s = LOAD_PULSE;
                    end else if (timer_done_s) begin
                        next_state_s  = ST_RUN;
                    end else begin
                        next_state_s  = state_r;
                    end
                end
                ST_PULSE: begin
                    if (timer_done_s) begin
                        next_state_s  = ST_GAP;
                        timer_load_s  = 1'b1;
                        timer_value_s = LOAD_GAP;
                    end else begin
                        next_state_s  = ST_PULSE;
                    end
                end
                ST_RUN: begin
                    if (accept_s && (delta_mod_s != '0)) begin
                        next_state_s  = ST_PULSE;
                        timer_load_s  = 1'b1;
                        timer_value_s = LOAD_PULSE;
                    end else begin
                        next_state_s  = ST_RUN;
                    end
                end
                default: begin
                    next_state_s  = ST_HOLD;
                    timer_load_s  = 1'b1;
                    timer_value_s = LOAD_HOLD;
                end
            endcase
        end
    end

    // State register, registered outputs, pending-step count and phase accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HOLD;
            div_resetn  <= 1'b0;
            div_calib   <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b1;
            phase_ready <= 1'b0;
            phase       <= '0;
            pending_r   <= INIT_PENDING;
        end else begin
            state_r     <= next_state_s;
            // Outputs decode the state being entered so they line up with it.
            div_resetn  <= (next_state_s != ST_HOLD);
            div_calib   <= (next_state_s == ST_PULSE);
            ready       <= (next_state_s == ST_RUN);
            busy        <= (next_state_s != ST_RUN);
            phase_ready <= (next_state_s == ST_RUN);
            if (next_state_s == ST_HOLD) begin
                phase     <= '0;
                pending_r <= INIT_PENDING;
            end else if ((state_r == ST_PULSE) && (next_state_s == ST_GAP)) begin
                // A step only counts once its pulse completed in full.
                phase     <= phase_inc_s;
                pending_r <= pending_r - PHW'(1);
            end else if (accept_s) begin
                pending_r <= delta_mod_s;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule
